mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma_if.sv | 30 +++
 rtl/mem_copy_dma.sv | 160 ++++++++++++++++
 tb/tb_mem_copy_dma.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_dma_if.sv
// Data-RAM request bus between the copy engine (master) and a single-cycle RAM (slave).
// Read data is combinational on address/flag; no backpressure on either side.
interface mem_copy_dma_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] ram_a;
   logic              ram_re;
   logic              ram_we;
   logic [1:0]        ram_flag;
   logic [31:0]       ram_wd;
   logic [31:0]       ram_rd;

   modport master (
      output ram_a,
      output ram_re,
      output ram_we,
      output ram_flag,
      output ram_wd,
      input  ram_rd
   );

   modport slave (
      input  ram_a,
      input  ram_re,
      input  ram_we,
      input  ram_flag,
      input  ram_wd,
      output ram_rd
   );
endinterface

// File: rtl/mem_copy_dma.sv
// Memory-to-memory copy engine: read-then-write per unit, 2 cycles/unit + 1 DONE cycle, no backpressure.
// Optional running checksum of written data enabled by MEM_COPY_CSUM_EN.
module mem_copy_dma #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
   input  logic [1:0]        size,
   mem_copy_dma_if.master    ram,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  count
`ifdef MEM_COPY_CSUM_EN
   ,
   output logic [31:0]       csum
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_ILLEGAL = 2'b10;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [ADDR_W-1:0] a_hold;
   logic [ADDR_W-1:0] stride;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W:0]    cnt_inc;
   logic [1:0]        size_q;
   logic [31:0]       data_q;
   logic              err_q;
   logic              last_unit;
   logic              go_read;

   always_comb begin
      stride = ADDR_W'(4);
      case (size_q)
         2'b00:   stride = ADDR_W'(1);
         2'b01:   stride = ADDR_W'(2);
         default: stride = ADDR_W'(4);
      endcase
   end

   // Extra bit so count+1 never wraps before the compare against len.
   assign cnt_inc   = {1'b0, cnt_q} + (LEN_W+1)'(1);
   assign last_unit = cnt_inc >= {1'b0, len_q};
   assign go_read   = (len != '0) && (size != SIZE_ILLEGAL);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = go_read ? READ : DONE;
            end
         end
         READ:    state_nxt = WRITE;
         WRITE:   state_nxt = last_unit ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are gated by reset so a reset cycle never issues an access.
   always_comb begin
      ram.ram_a  = a_hold;
      ram.ram_re = 1'b0;
      ram.ram_we = 1'b0;
      case (state)
         READ: begin
            ram.ram_a  = src_ptr;
            ram.ram_re = reset;
         end
         WRITE: begin
            ram.ram_a  = dst_ptr;
            ram.ram_we = reset;
         end
         default: ;
      endcase
   end

   assign ram.ram_flag = size_q;
   assign ram.ram_wd   = data_q;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign err          = err_q;
   assign count        = cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         src_ptr <= '0;
         dst_ptr <= '0;
         a_hold  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         size_q  <= 2'b00;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt_q <= '0;
                  err_q <= (size == SIZE_ILLEGAL);
                  if (go_read) begin
                     src_ptr <= src;
                     dst_ptr <= dst;
                     len_q   <= len;
                     size_q  <= size;
                  end
               end
            end
            READ: begin
               data_q <= ram.ram_rd;
               a_hold <= src_ptr;
            end
            WRITE: begin
               src_ptr <= src_ptr + stride;
               dst_ptr <= dst_ptr + stride;
               cnt_q   <= cnt_q + LEN_W'(1);
               a_hold  <= dst_ptr;
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_COPY_CSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         csum_q <= '0;
      end else if (state == IDLE && start) begin
         csum_q <= '0;
      end else if (state == WRITE) begin
         csum_q <= csum_q + data_q;
      end
   end

   assign csum = csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: directed vector table, reset corner case, randomized copies vs a byte-array model.
module tb_mem_copy_dma;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] src, dst, len;
   logic [1:0] size;
   logic       busy, done, err;
   logic [7:0] count;
`ifdef MEM_COPY_CSUM_EN
   logic [31:0] csum;
`endif

   mem_copy_dma_if #(.ADDR_W(8)) ram_bus ();

   mem_copy_dma #(.ADDR_W(8), .LEN_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .src   (src),
      .dst   (dst),
      .len   (len),
      .size  (size),
      .ram   (ram_bus),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .count (count)
`ifdef MEM_COPY_CSUM_EN
      ,
      .csum  (csum)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- RAM environment ----------------
   logic [7:0]  mem [256];
   logic [7:0]  ra0, ra1, ra2, ra3;
   logic [31:0] rd_v;
   logic        load_en = 1'b0;
   logic        load_rand = 1'b0;
   int          n_re = 0;
   int          n_we = 0;

   always_comb begin
      ra0 = ram_bus.ram_a;
      ra1 = ra0 + 8'd1;
      ra2 = ra0 + 8'd2;
      ra3 = ra0 + 8'd3;
      case (ram_bus.ram_flag)
         2'b00:   rd_v = {{24{mem[ra0][7]}}, mem[ra0]};
         2'b01:   rd_v = {{16{mem[ra1][7]}}, mem[ra1], mem[ra0]};
         default: rd_v = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
      endcase
   end
   assign ram_bus.ram_rd = rd_v;

   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= load_rand ? 8'($urandom) : 8'(i);
      end else if (ram_bus.ram_we) begin
         mem[ra0] <= ram_bus.ram_wd[7:0];
         if (ram_bus.ram_flag != 2'b00) mem[ra1] <= ram_bus.ram_wd[15:8];
         if (ram_bus.ram_flag == 2'b11) begin
            mem[ra2] <= ram_bus.ram_wd[23:16];
            mem[ra3] <= ram_bus.ram_wd[31:24];
         end
      end
   end

   always @(posedge clk) begin
      if (ram_bus.ram_re) n_re <= n_re + 1;
      if (ram_bus.ram_we) n_we <= n_we + 1;
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: whole units copied in ascending order, each fully read before being written.
   logic [7:0] ref_mem [256];

   function automatic logic [31:0] unit_val(input logic [7:0] b0, b1, b2, b3, input logic [1:0] sz);
      if (sz == 2'b00) return {{24{b0[7]}}, b0};
      if (sz == 2'b01) return {{16{b1[7]}}, b1, b0};
      return {b3, b2, b1, b0};
   endfunction

   task automatic model_copy(input logic [7:0] s, d, l, input logic [1:0] sz, output logic [31:0] sum);
      int         stride;
      logic [7:0] b [4];
      logic [7:0] sa, da;
      sum    = 32'd0;
      stride = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      if (sz == 2'b10 || l == 8'd0) return;
      for (int u = 0; u < int'(l); u++) begin
         sa = 8'(int'(s) + u * stride);
         da = 8'(int'(d) + u * stride);
         for (int k = 0; k < 4; k++) b[k] = 8'd0;
         for (int k = 0; k < stride; k++) b[k] = ref_mem[8'(int'(sa) + k)];
         sum = sum + unit_val(b[0], b[1], b[2], b[3], sz);
         for (int k = 0; k < stride; k++) ref_mem[8'(int'(da) + k)] = b[k];
      end
   endtask

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   task automatic load_ram(input bit rnd);
      @(negedge clk);
      load_en   = 1'b1;
      load_rand = rnd;
      @(negedge clk);
      load_en = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
   endtask

   typedef struct {
      logic [7:0] src;
      logic [7:0] dst;
      logic [7:0] len;
      logic [1:0] size;
      int         exp_lat;
      logic       exp_err;
      logic [7:0] exp_cnt;
      bit         use_chk;
      logic [7:0] chk_a;
      logic [7:0] chk_d;
   } vec_t;

   task automatic run(input vec_t v, input bit noise);
      int          lat, re0, we0, n;
      logic [31:0] sum;
      model_copy(v.src, v.dst, v.len, v.size, sum);
      n   = (v.size == 2'b10 || v.len == 8'd0) ? 0 : int'(v.len);
      re0 = n_re;
      we0 = n_we;
      @(negedge clk);
      start = 1'b1; src = v.src; dst = v.dst; len = v.len; size = v.size;
      @(negedge clk);
      lat = 1;
      // A start pulse while busy must be ignored.
      if (noise && !done) begin
         start = 1'b1; src = 8'($urandom); dst = 8'($urandom);
         len = 8'($urandom); size = 2'($urandom);
      end else begin
         start = 1'b0;
      end
      while (!done && lat < 100) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      start = 1'b0;
      chk("done_latency", 32'(lat), 32'(v.exp_lat));
      chk("err_in_done", 32'(err), 32'(v.exp_err));
      chk("count_in_done", 32'(count), 32'(v.exp_cnt));
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("no_access_in_done", {30'd0, ram_bus.ram_re, ram_bus.ram_we}, 32'd0);
      @(negedge clk);
      chk("busy_after", 32'(busy), 32'd0);
      chk("done_after", 32'(done), 32'd0);
      chk("err_held", 32'(err), 32'(v.exp_err));
      chk("read_count", 32'(n_re - re0), 32'(n));
      chk("write_count", 32'(n_we - we0), 32'(n));
      chk("mem_vs_model", 32'(mem_diffs()), 32'd0);
      if (v.use_chk) chk("mem_byte", 32'(mem[v.chk_a]), 32'(v.chk_d));
`ifdef MEM_COPY_CSUM_EN
      chk("csum", csum, sum);
`endif
   endtask

   vec_t vecs [7];

   initial begin
      int   lat_r;
      bit   seen_done;
      vec_t rv;

      vecs[0] = '{8'h10, 8'h80, 8'd2, 2'b11, 5, 1'b0, 8'd2, 1'b1, 8'h87, 8'h17};
      vecs[1] = '{8'h90, 8'hC0, 8'd1, 2'b00, 3, 1'b0, 8'd1, 1'b1, 8'hC0, 8'h90};
      vecs[2] = '{8'h20, 8'h21, 8'd3, 2'b00, 7, 1'b0, 8'd3, 1'b1, 8'h23, 8'h20};
      vecs[3] = '{8'hFE, 8'h40, 8'd4, 2'b00, 9, 1'b0, 8'd4, 1'b1, 8'h43, 8'h01};
      vecs[4] = '{8'h10, 8'h80, 8'd0, 2'b11, 1, 1'b0, 8'd0, 1'b1, 8'h80, 8'h80};
      vecs[5] = '{8'h10, 8'h80, 8'd2, 2'b10, 1, 1'b1, 8'd0, 1'b1, 8'h80, 8'h80};
      vecs[6] = '{8'h30, 8'h50, 8'd2, 2'b01, 5, 1'b0, 8'd2, 1'b1, 8'h53, 8'h33};

      reset = 1'b0; start = 1'b0; src = 8'd0; dst = 8'd0; len = 8'd0; size = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ram_a", 32'(ram_bus.ram_a), 32'd0);
      chk("rst_ram_flag", 32'(ram_bus.ram_flag), 32'd0);
      chk("rst_ram_wd", ram_bus.ram_wd, 32'd0);
      chk("rst_strobes", {30'd0, ram_bus.ram_re, ram_bus.ram_we}, 32'd0);
      reset = 1'b1;

      // Directed table, RAM[i]=i before each vector; illegal size precedes a legal one to see err clear.
      for (int i = 0; i < 7; i++) begin
         load_ram(1'b0);
         run(vecs[i], 1'b0);
      end

      // Reset asserted during the second WRITE of a 4-word copy.
      load_ram(1'b0);
      lat_r = n_we;
      @(negedge clk);
      start = 1'b1; src = 8'h10; dst = 8'h80; len = 8'd4; size = 2'b11;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_we_before_reset", 32'(ram_bus.ram_we), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_we_gated", 32'(ram_bus.ram_we), 32'd0);
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_count", 32'(count), 32'd0);
      chk("mid_ram_a", 32'(ram_bus.ram_a), 32'd0);
      chk("mid_ram_wd", ram_bus.ram_wd, 32'd0);
      reset = 1'b1;
      seen_done = done;
      repeat (6) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      chk("mid_no_done", 32'(seen_done), 32'd0);
      chk("mid_writes", 32'(n_we - lat_r), 32'd1);
      for (int k = 0; k < 8; k++)
         chk("mid_mem", 32'(mem[8'h80 + 8'(k)]), (k < 4) ? 32'(8'h10 + 8'(k)) : 32'(8'h80 + 8'(k)));

      // Randomized copies against the model, with ignored start pulses mixed in.
      for (int it = 0; it < 40; it++) begin
         load_ram(1'b1);
         rv.src     = 8'($urandom);
         rv.dst     = 8'($urandom);
         rv.len     = 8'($urandom_range(0, 8));
         rv.size    = ($urandom_range(0, 9) == 0) ? 2'b10 : ((it % 3 == 0) ? 2'b00 : (it % 3 == 1) ? 2'b01 : 2'b11);
         rv.exp_err = (rv.size == 2'b10);
         rv.exp_cnt = rv.exp_err ? 8'd0 : rv.len;
         rv.exp_lat = (rv.exp_err || rv.len == 8'd0) ? 1 : 2 * int'(rv.len) + 1;
         rv.use_chk = 1'b0;
         rv.chk_a   = 8'd0;
         rv.chk_d   = 8'd0;
         run(rv, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
